inst_refill_ctrl: RTL

Miss-side refill engine for the direct-mapped L1 instruction cache (8 lines × 128-bit, tag = addr[31:7], index = addr[6:4], word offset = addr[3:2]). It accepts a miss address and fetches the four 32-bit words of the line from word-wide main memory. It then presents one line-aligned 128-bit fill beat to the cache in the same word order the cache reads back: word0 in [31:0] through word3 in [127:96]. It also reports memory timeouts so the fetch stage never hangs silently.

---
 rtl/inst_refill_ctrl_pkg.sv | 18 +
 rtl/inst_refill_ctrl_refill_line_assembler.sv | 40 ++++
 rtl/inst_refill_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/inst_refill_ctrl_pkg.sv
// Shared definitions for the L1 instruction-cache refill path.
// The cache uses the same address field constants to split tag/index/offset.
package inst_refill_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        ERR  = 2'd3
    } refill_state_t;

    localparam int LINE_BYTES = 16;
    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = 4;
    localparam int TAG_LSB    = 7;
    localparam int WORD_W     = 32;

endpackage

// File: rtl/inst_refill_ctrl_refill_line_assembler.sv
// Line buffer for the refill engine: one 32-bit slot per beat plus a merged
// view that already contains the word being written this cycle.
module refill_line_assembler
    import inst_refill_ctrl_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int BEAT_W     = $clog2(LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         we,
    input  logic [BEAT_W-1:0]            beat,
    input  logic [WORD_W-1:0]            wdata,
    output logic [LINE_WORDS*WORD_W-1:0] line_next
);

    logic [LINE_WORDS-1:0][WORD_W-1:0] words;
    logic [LINE_WORDS-1:0][WORD_W-1:0] merged;

    // The merged view lets the controller capture a complete line on the
    // same edge that stores the last word, saving a cycle of fill latency.
    always_comb begin
        merged = words;
        if (we) begin
            merged[beat] = wdata;
        end
    end

    assign line_next = merged;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            words <= '0;
        end else if (we) begin
            words[beat] <= wdata;
        end
    end

endmodule

// File: rtl/inst_refill_ctrl.sv
// Miss-side refill engine: fetches the four words of a line from word-wide
// memory and delivers them to the instruction cache as one 128-bit fill beat.
module inst_refill_ctrl
    import inst_refill_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         req_valid,
    input  logic [ADDR_W-1:0]            req_addr,
    output logic                         req_ready,
    output logic                         mem_rd,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [WORD_W-1:0]            mem_rdata,
    input  logic                         mem_ready,
    output logic                         fill_valid,
    output logic [ADDR_W-1:0]            fill_addr,
    output logic [LINE_WORDS*WORD_W-1:0] fill_data,
    output logic                         busy,
    output logic                         err
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int TMO_W  = $clog2(TIMEOUT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    refill_state_t           state;
    logic [ADDR_W-1:0]       base;
    logic [BEAT_W-1:0]       beat;
    logic [BEAT_W-1:0]       beat_next;
    logic [TMO_W-1:0]        tmo;
    logic [ADDR_W-1:0]       req_line;
    logic                    word_we;
    logic                    buf_clear;
    logic [LINE_WORDS*WORD_W-1:0] line_next;
    logic                    unused_addr_bits;

    assign req_line         = {req_addr[ADDR_W-1:INDEX_LSB], {INDEX_LSB{1'b0}}};
    assign unused_addr_bits = ^req_addr[INDEX_LSB-1:0];

    // The beat counter only spans the word-offset bits, so stepping through
    // the line can never carry into the index or tag.
    assign beat_next = beat + 1'b1;
    assign word_we   = (state == REQ) && mem_ready;
    assign buf_clear = (state == ERR);

    refill_line_assembler #(
        .LINE_WORDS (LINE_WORDS),
        .BEAT_W     (BEAT_W)
    ) u_assembler (
        .clk       (Clk),
        .reset_n   (Reset_n),
        .clear     (buf_clear),
        .we        (word_we),
        .beat      (beat),
        .wdata     (mem_rdata),
        .line_next (line_next)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            base       <= '0;
            beat       <= '0;
            tmo        <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            fill_valid <= 1'b0;
            fill_addr  <= '0;
            fill_data  <= '0;
            err        <= 1'b0;
        end else begin
            fill_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base      <= req_line;
                        beat      <= '0;
                        tmo       <= '0;
                        mem_addr  <= req_line;
                        mem_rd    <= 1'b1;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        tmo <= '0;
                        if (beat == BEAT_LAST) begin
                            mem_rd     <= 1'b0;
                            fill_valid <= 1'b1;
                            fill_addr  <= base;
                            fill_data  <= line_next;
                            state      <= FILL;
                        end else begin
                            beat     <= beat_next;
                            mem_addr <= {base[ADDR_W-1:INDEX_LSB], beat_next,
                                         {OFFSET_LSB{1'b0}}};
                        end
                    end else if (tmo == TMO_LAST) begin
                        // Give up on this line; the fetch stage sees err and retries.
                        mem_rd <= 1'b0;
                        err    <= 1'b1;
                        state  <= ERR;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                FILL, ERR: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
